sysid_regs: RTL and testbench

Parametrised system-identification register block on the Avalon-MM control bus. Successor to the fixed two-word ID/timestamp slave: adds a version/capability word, a byte-writable scratch register, a free-running uptime counter with atomic 64-bit readout, and a configurable number of user status words. Host software probes it first to confirm the FPGA image, bus health and uptime.

---
 rtl/sysid_pkg.sv | 32 +++
 rtl/sysid_uptime_ctr.sv | 43 ++++
 rtl/sysid_regs.sv | 111 +++++++++++
 tb/tb_sysid_regs.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_pkg.sv
// sysid_pkg: shared constants for the system-identification register block.
//   - Word addresses of every mapped register.
//   - Bit offsets of the fields packed into the CAPS word.
//   - The value returned for reserved or unmapped reads.
package sysid_pkg;

  localparam int unsigned ADDR_ID        = 0;
  localparam int unsigned ADDR_TIMESTAMP = 1;
  localparam int unsigned ADDR_UPTIME_LO = 2;
  localparam int unsigned ADDR_UPTIME_HI = 3;
  localparam int unsigned ADDR_SCRATCH   = 4;
  localparam int unsigned ADDR_CAPS      = 5;
  localparam int unsigned ADDR_USER_BASE = 8;

  localparam int unsigned CAPS_VERSION_LSB  = 16;
  localparam int unsigned CAPS_UPTIME_W_LSB = 8;
  localparam int unsigned CAPS_NUM_USER_LSB = 0;

  localparam logic [31:0] UNMAPPED_VALUE = 32'h0;

  // Layout: VERSION in [31:16], UPTIME_W in [15:8], NUM_USER in [7:0].
  function automatic logic [31:0] caps_word(logic [15:0] version, int unsigned uptime_w,
                                            int unsigned num_user);
    logic [31:0] w;
    w = '0;
    w[CAPS_VERSION_LSB  +: 16] = version;
    w[CAPS_UPTIME_W_LSB +: 8]  = 8'(uptime_w);
    w[CAPS_NUM_USER_LSB +: 8]  = 8'(num_user);
    return w;
  endfunction

endpackage

// File: rtl/sysid_uptime_ctr.sv
// sysid_uptime_ctr: free-running uptime counter with an atomic 64-bit readout.
//   clk, reset_n : clock and asynchronous active-low reset
//   clear        : load the counter with 0 on this edge (count resumes next cycle)
//   snap         : low word is being read; latch the high bits into the shadow
//   lo           : live counter bits [31:0]
//   hi_shadow    : high bits captured at the last snap, zero-extended
module sysid_uptime_ctr #(
  parameter int unsigned UPTIME_W = 48
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        snap,
  output logic [31:0] lo,
  output logic [31:0] hi_shadow
);

  logic [UPTIME_W-1:0] cnt_q;
  logic [UPTIME_W-1:0] cnt_d;
  logic [31:0]         shadow_q;
  logic [63:0]         cnt_ext;

  // Continuous assignment keeps the next-state a plain net.
  assign cnt_d   = clear ? '0 : cnt_q + UPTIME_W'(1);
  assign cnt_ext = 64'(cnt_q);

  // Shadow takes the same pre-edge sample that lo presents, so LO/HI pair atomically.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (snap) begin
        shadow_q <= cnt_ext[63:32];
      end
    end
  end

  assign lo        = cnt_ext[31:0];
  assign hi_shadow = shadow_q;

endmodule

// File: rtl/sysid_regs.sv
// sysid_regs: Avalon-MM system-identification register block.
//   clk, reset_n       : clock and asynchronous active-low reset
//   address            : word address (ADDR_W bits)
//   read, write        : bus strobes; the slave never stalls
//   writedata          : write data, byteenable selects the lanes
//   readdata           : read data, held between responses
//   readdatavalid      : one-cycle strobe, one cycle after the read
//   user_status        : NUM_USER status words, registered every cycle
module sysid_regs
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID = 32'h5353_4F43,
  parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
  parameter logic [15:0] VERSION   = 16'h0002,
  parameter int unsigned NUM_USER  = 4,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned UPTIME_W  = 48
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    read,
  input  logic                    write,
  input  logic [31:0]             writedata,
  input  logic [3:0]              byteenable,
  output logic [31:0]             readdata,
  output logic                    readdatavalid,
  input  logic [32*NUM_USER-1:0]  user_status
);

  localparam logic [31:0] CapsWord = caps_word(VERSION, UPTIME_W, NUM_USER);

  logic [31:0]            addr_ext;
  logic                   cnt_clear;
  logic                   cnt_snap;
  logic [31:0]            uptime_lo;
  logic [31:0]            uptime_hi;
  logic [31:0]            scratch_q;
  logic [31:0]            scratch_d;
  logic [32*NUM_USER-1:0] user_q;
  logic [31:0]            rdata;
  logic [31:0]            readdata_q;
  logic                   rvalid_q;

  // Widened so the user-range bound cannot alias when it equals 2**ADDR_W.
  assign addr_ext  = 32'(address);
  assign cnt_clear = write && (addr_ext == ADDR_UPTIME_LO);
  assign cnt_snap  = read && (addr_ext == ADDR_UPTIME_LO);

  sysid_uptime_ctr #(
    .UPTIME_W (UPTIME_W)
  ) u_uptime (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (cnt_clear),
    .snap      (cnt_snap),
    .lo        (uptime_lo),
    .hi_shadow (uptime_hi)
  );

  always_comb begin
    scratch_d = scratch_q;
    if (write && (addr_ext == ADDR_SCRATCH)) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) begin
          scratch_d[8*b +: 8] = writedata[8*b +: 8];
        end
      end
    end
  end

  // Read mux sees pre-edge state, so a colliding write never leaks into the response.
  always_comb begin
    rdata = UNMAPPED_VALUE;
    case (addr_ext)
      ADDR_ID:        rdata = SYSTEM_ID;
      ADDR_TIMESTAMP: rdata = TIMESTAMP;
      ADDR_UPTIME_LO: rdata = uptime_lo;
      ADDR_UPTIME_HI: rdata = uptime_hi;
      ADDR_SCRATCH:   rdata = scratch_q;
      ADDR_CAPS:      rdata = CapsWord;
      default: begin
        for (int unsigned k = 0; k < NUM_USER; k++) begin
          if (addr_ext == ADDR_USER_BASE + k) begin
            rdata = user_q[32*k +: 32];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
      rvalid_q   <= 1'b0;
      scratch_q  <= '0;
      user_q     <= '0;
    end else begin
      rvalid_q  <= read;
      scratch_q <= scratch_d;
      user_q    <= user_status;
      if (read) begin
        readdata_q <= rdata;
      end
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_sysid_regs.sv
module tb_sysid_regs;

  localparam logic [31:0] SYSID = 32'h5353_4F43;
  localparam logic [31:0] TS    = 32'h6612_0A0B;
  localparam int          NU    = 4;
  localparam int          UW    = 48;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [3:0]        address = '0;
  logic              read = 1'b0;
  logic              write = 1'b0;
  logic [31:0]       writedata = '0;
  logic [3:0]        byteenable = '0;
  logic [31:0]       readdata;
  logic              readdatavalid;
  logic [32*NU-1:0]  user_status = '0;

  sysid_regs #(
    .SYSTEM_ID (SYSID),
    .TIMESTAMP (TS),
    .VERSION   (16'h0002),
    .NUM_USER  (NU),
    .ADDR_W    (4),
    .UPTIME_W  (UW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .user_status   (user_status)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (spec-level: a count, a shadow, a scratch word, user words).
  logic [63:0] m_up;
  logic [31:0] m_shadow;
  logic [31:0] m_scratch;
  logic [31:0] m_user [NU];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;
  logic        force_req = 1'b0;
  logic [63:0] force_val = '0;

  localparam logic [63:0] UP_MASK = (64'd1 << UW) - 64'd1;

  function automatic logic [31:0] ref_read(int a);
    if (a == 0) return SYSID;
    if (a == 1) return TS;
    if (a == 2) return m_up[31:0];
    if (a == 3) return m_shadow;
    if (a == 4) return m_scratch;
    if (a == 5) return 32'h0002_3004;
    if (a >= 8 && a < 8 + NU) return m_user[a-8];
    return 32'h0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_up      <= '0;
      m_shadow  <= '0;
      m_scratch <= '0;
      for (int k = 0; k < NU; k++) m_user[k] <= '0;
      exp_q.delete();
    end else begin
      if (read) begin
        exp_q.push_back(ref_read(int'(address)));
        if (address == 4'd2) m_shadow <= m_up[63:32];
      end
      if (force_req) m_up <= force_val;
      else if (write && address == 4'd2) m_up <= '0;
      else m_up <= (m_up + 64'd1) & UP_MASK;
      if (write && address == 4'd4) begin
        for (int b = 0; b < 4; b++)
          if (byteenable[b]) m_scratch[8*b +: 8] <= writedata[8*b +: 8];
      end
      for (int k = 0; k < NU; k++) m_user[k] <= user_status[32*k +: 32];
    end
  end

  // Monitor: one response exactly one cycle after each read; readdata held otherwise.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset_n) begin
      last_rd = 32'h0;
    end else begin
      n_checks++;
      if (readdatavalid !== (exp_q.size() != 0)) begin
        n_fail++;
        $display("FAIL rdv: got %b expected %b", readdatavalid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (readdata !== e) begin
          n_fail++;
          $display("FAIL rdata: got %h expected %h", readdata, e);
        end
        last_rd = e;
      end else begin
        n_checks++;
        if (readdata !== last_rd) begin
          n_fail++;
          $display("FAIL hold: got %h expected %h", readdata, last_rd);
        end
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(logic r, logic w, int a, logic [31:0] d, logic [3:0] be);
    @(negedge clk);
    read = r;
    write = w;
    address = 4'(a);
    writedata = d;
    byteenable = be;
  endtask

  task automatic rd(int a);
    cyc(1'b1, 1'b0, a, 32'h0, 4'h0);
  endtask

  task automatic wr(int a, logic [31:0] d, logic [3:0] be);
    cyc(1'b0, 1'b1, a, d, be);
  endtask

  task automatic nop();
    cyc(1'b0, 1'b0, 0, 32'h0, 4'h0);
  endtask

  // Load the counter through its next-state net for one edge.
  task automatic load_counter(logic [47:0] v);
    nop();
    force dut.u_uptime.cnt_d = v;
    force_val = 64'(v);
    force_req = 1'b1;
    @(negedge clk);
    release dut.u_uptime.cnt_d;
    force_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    read = 1'b0;
    write = 1'b0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    #1;
    check("reset_rdata", readdata, 32'h0);
    check("reset_rdv", 32'(readdatavalid), 32'h0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;

    // ID, timestamp, caps back to back.
    rd(0); rd(1); rd(5); nop();

    // Byte-lane scratch writes.
    wr(4, 32'hA5A5_A5A5, 4'hF);
    wr(4, 32'h0000_3C00, 4'b0010);
    rd(4); nop();

    // 32-bit carry into the shadow.
    load_counter(48'h0000_FFFF_FFFD);
    rd(2); rd(3); rd(2); rd(3); rd(2); rd(3);
    nop(); nop(); rd(3); rd(2); rd(3);

    // Clear then read three edges later.
    wr(2, $urandom, 4'($urandom));
    nop(); nop(); rd(2); nop();

    // Full-width wrap.
    load_counter(48'hFFFF_FFFF_FFFD);
    rd(2); rd(2); rd(2); rd(3); nop();

    // User words, reserved and unmapped addresses, RO write.
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    for (int k = 0; k < NU; k++) user_status[32*k +: 32] = $urandom;
    user_status[64 +: 32] = 32'h1234_5678;
    rd(10); rd(6); rd(12); rd(15); rd(8);
    wr(0, 32'hDEAD_BEEF, 4'hF); rd(0);

    // Protocol collisions: read and write together.
    cyc(1'b1, 1'b1, 4, 32'h1122_3344, 4'hF);
    rd(4);
    cyc(1'b1, 1'b1, 2, 32'h0, 4'h0);
    rd(3); rd(2); nop();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      read = ($urandom_range(0, 2) != 0);
      write = ($urandom_range(0, 3) == 0);
      address = 4'($urandom_range(0, 15));
      writedata = $urandom;
      byteenable = 4'($urandom);
      for (int k = 0; k < NU; k++) user_status[32*k +: 32] = $urandom;
    end
    nop(); nop();

    // Reset while a response is on the bus.
    rd(4);
    @(posedge clk);
    #1;
    check("rdv_before_reset", 32'(readdatavalid), 32'h1);
    reset_n = 1'b0;
    read = 1'b0;
    #1;
    check("rdv_dropped", 32'(readdatavalid), 32'h0);
    check("rdata_reset", readdata, 32'h0);
    @(negedge clk);
    #2 reset_n = 1'b1;

    // Reset in the same cycle as a read.
    @(negedge clk);
    read = 1'b1; address = 4'd4;
    #2 reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("rdv_in_reset", 32'(readdatavalid), 32'h0);
    @(negedge clk);
    read = 1'b0;
    #2 reset_n = 1'b1;
    rd(4); rd(2); rd(3); nop(); nop();
    do_reset();
    rd(2); nop();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
